// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: constants and types shared by the fetch program counter.
//
// Contents:
//   RstEnable            reset-asserted level of the active-low rst input
//   ChipEnable/Disable   ROM chip-enable levels
//   JumpEnable           branch_flag_i level that means "branch taken"
//   StallEnable          stall_i level that means "hold the fetch stage"
//   ExcEnable            exc_flag_i level that means "exception redirect"
//   pc_sel_e             next-PC source chosen by the priority logic
//   sel_is_redirect()    true when a source loads pc non-sequentially
package pc_gen_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic JumpEnable  = 1'b1;
  localparam logic StallEnable = 1'b1;
  localparam logic ExcEnable   = 1'b1;

  // Next-PC source, listed in decreasing priority.
  typedef enum logic [2:0] {
    SelBoot,   // ROM not yet enabled: pin pc to the reset vector
    SelExc,    // exception/flush redirect
    SelStall,  // fetch stalled: hold pc, maybe buffer a branch
    SelBranch, // live branch/jump
    SelPend,   // replay a branch buffered during an earlier stall
    SelSeq     // sequential increment
  } pc_sel_e;

  function automatic logic sel_is_redirect(input pc_sel_e sel);
    return (sel == SelExc) || (sel == SelBranch) || (sel == SelPend);
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry buffer for a branch resolved while fetch is stalled.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset; empties the buffer
//   capture       load capture_addr and mark the entry valid
//   capture_addr  branch target to buffer
//   clear         discard the entry (wins over capture and consume)
//   consume       entry has been applied to pc; mark it invalid
//   pend_valid    entry holds a target not yet applied
//   pend_addr     buffered target
//
// A capture while already valid overwrites the address, so the youngest
// branch seen during a stall is the one replayed.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [ADDR_W-1:0] capture_addr,
  input  logic              clear,
  input  logic              consume,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      addr_d  = capture_addr;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign pend_valid = valid_q;
  assign pend_addr  = addr_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter driving the instruction ROM address and enable.
//
// Ports:
//   clk                   system clock, state updates on posedge
//   rst                   asynchronous active-low reset
//   stall_i               hold pc (fetch stage stalled)
//   branch_flag_i         branch/jump taken this cycle
//   branch_target_addr_i  branch/jump target
//   exc_flag_i            exception/flush redirect (highest priority)
//   exc_target_addr_i     exception handler address
//   pc                    current fetch address
//   ce                    ROM chip enable
//   redirect_o            pc was loaded non-sequentially on the last edge
//   misalign_o            low log2(INC_STEP) bits of pc nonzero
//
// Priority with ce = 1: exception > stall > branch > buffered branch > increment.
// A branch seen during a stall is parked in pc_redirect_buf and replayed on the
// first unstalled edge unless an exception or a newer live branch supersedes it.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_addr_i,
  input  logic              exc_flag_i,
  input  logic [ADDR_W-1:0] exc_target_addr_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redirect_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] IncStep = ADDR_W'(INC_STEP);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q;
  logic              redirect_q, redirect_d;
  pc_sel_e           sel;

  logic              buf_capture;
  logic              buf_clear;
  logic              buf_consume;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;

  // Source selection in priority order.
  always_comb begin
    sel = SelSeq;
    if (ce_q == ChipDisable) begin
      sel = SelBoot;
    end else if (exc_flag_i == ExcEnable) begin
      sel = SelExc;
    end else if (stall_i == StallEnable) begin
      sel = SelStall;
    end else if (branch_flag_i == JumpEnable) begin
      sel = SelBranch;
    end else if (pend_valid) begin
      sel = SelPend;
    end
  end

  // Next pc and buffer controls.
  always_comb begin
    pc_d        = pc_q;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    buf_consume = 1'b0;
    unique case (sel)
      SelBoot: begin
        pc_d      = RESET_VEC;
        buf_clear = 1'b1;
      end
      SelExc: begin
        pc_d      = exc_target_addr_i;
        buf_clear = 1'b1;
      end
      SelStall: begin
        buf_capture = (branch_flag_i == JumpEnable);
      end
      SelBranch: begin
        pc_d      = branch_target_addr_i;
        buf_clear = 1'b1;
      end
      SelPend: begin
        pc_d        = pend_addr;
        buf_consume = 1'b1;
      end
      SelSeq: begin
        pc_d = pc_q + IncStep;
      end
    endcase
    redirect_d = sel_is_redirect(sel);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      ce_q       <= ChipDisable;
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
    end else begin
      ce_q       <= ChipEnable;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk          (clk),
    .rst          (rst),
    .capture      (buf_capture),
    .capture_addr (branch_target_addr_i),
    .clear        (buf_clear),
    .consume      (buf_consume),
    .pend_valid   (pend_valid),
    .pend_addr    (pend_addr)
  );

  assign pc         = pc_q;
  assign ce         = ce_q;
  assign redirect_o = redirect_q;

  generate
    if (INC_STEP <= 1) begin : g_no_align
      assign misalign_o = 1'b0;
    end else begin : g_align
      localparam int unsigned LowBits = $clog2(INC_STEP);
      assign misalign_o = |pc_q[LowBits-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen.
// dut32: ADDR_W=32, INC_STEP=4, RESET_VEC=0x100 (reset, branch, stall, exception).
// dut8:  ADDR_W=8,  INC_STEP=4, RESET_VEC=0x00  (wrap, misalignment).
module tb_pc_gen;

  logic clk;
  logic rst32, rst8;

  logic        stall32, br32, exc32;
  logic [31:0] bt32, et32;
  logic [31:0] pc32;
  logic        ce32, red32, mis32;

  logic        stall8, br8, exc8;
  logic [7:0]  bt8, et8;
  logic [7:0]  pc8;
  logic        ce8, red8, mis8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is8;
    string       tag;
    logic [31:0] pc;
    logic        ce;
    logic        red;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_gen #(
    .ADDR_W    (32),
    .INC_STEP  (4),
    .RESET_VEC (32'h100)
  ) dut32 (
    .clk                  (clk),
    .rst                  (rst32),
    .stall_i              (stall32),
    .branch_flag_i        (br32),
    .branch_target_addr_i (bt32),
    .exc_flag_i           (exc32),
    .exc_target_addr_i    (et32),
    .pc                   (pc32),
    .ce                   (ce32),
    .redirect_o           (red32),
    .misalign_o           (mis32)
  );

  pc_gen #(
    .ADDR_W    (8),
    .INC_STEP  (4),
    .RESET_VEC (8'h00)
  ) dut8 (
    .clk                  (clk),
    .rst                  (rst8),
    .stall_i              (stall8),
    .branch_flag_i        (br8),
    .branch_target_addr_i (bt8),
    .exc_flag_i           (exc8),
    .exc_target_addr_i    (et8),
    .pc                   (pc8),
    .ce                   (ce8),
    .redirect_o           (red8),
    .misalign_o           (mis8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is8) begin
        check_val({e.tag, ".pc"},  {24'h0, pc8}, e.pc);
        check_val({e.tag, ".ce"},  {31'h0, ce8}, {31'h0, e.ce});
        check_val({e.tag, ".red"}, {31'h0, red8}, {31'h0, e.red});
        check_val({e.tag, ".mis"}, {31'h0, mis8}, {31'h0, e.mis});
      end else begin
        check_val({e.tag, ".pc"},  pc32, e.pc);
        check_val({e.tag, ".ce"},  {31'h0, ce32}, {31'h0, e.ce});
        check_val({e.tag, ".red"}, {31'h0, red32}, {31'h0, e.red});
        check_val({e.tag, ".mis"}, {31'h0, mis32}, {31'h0, e.mis});
      end
    end
  endtask

  // Drive one cycle on dut32, queue the expected post-edge state, then compare.
  task automatic step32(input string tag, input logic st, input logic br, input logic [31:0] bt,
                        input logic ex, input logic [31:0] et,
                        input logic [31:0] epc, input logic ered);
    exp_t e;
    stall32 = st; br32 = br; bt32 = bt; exc32 = ex; et32 = et;
    e.is8 = 1'b0; e.tag = tag; e.pc = epc; e.ce = 1'b1; e.red = ered; e.mis = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic step8(input string tag, input logic br, input logic [7:0] bt,
                       input logic [7:0] epc, input logic ered, input logic emis);
    exp_t e;
    stall8 = 1'b0; br8 = br; bt8 = bt; exc8 = 1'b0; et8 = 8'h0;
    e.is8 = 1'b1; e.tag = tag; e.pc = {24'h0, epc}; e.ce = 1'b1; e.red = ered; e.mis = emis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst32 = 1'b0; rst8 = 1'b0;
    stall32 = 1'b0; br32 = 1'b0; bt32 = '0; exc32 = 1'b0; et32 = '0;
    stall8 = 1'b0; br8 = 1'b0; bt8 = '0; exc8 = 1'b0; et8 = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.pc", pc32, 32'h100);
    check_val("rst.ce", {31'h0, ce32}, 32'h0);
    check_val("rst.red", {31'h0, red32}, 32'h0);
    rst32 = 1'b1;

    step32("boot0", 0, 0, 0, 0, 0, 32'h100, 0);
    step32("seq1",  0, 0, 0, 0, 0, 32'h104, 0);
    step32("seq2",  0, 0, 0, 0, 0, 32'h108, 0);

    // Branch.
    step32("br",     0, 1, 32'h200, 0, 0, 32'h200, 1);
    step32("br.seq", 0, 0, 0,       0, 0, 32'h204, 0);

    // Stall buffering: youngest branch wins, replayed on first unstalled edge.
    step32("st1",    1, 1, 32'h300, 0, 0, 32'h204, 0);
    step32("st2",    1, 1, 32'h400, 0, 0, 32'h204, 0);
    step32("st3",    1, 0, 0,       0, 0, 32'h204, 0);
    step32("replay", 0, 0, 0,       0, 0, 32'h400, 1);
    step32("rp.seq", 0, 0, 0,       0, 0, 32'h404, 0);

    // Exception beats stall and branch and discards a buffered entry.
    step32("exc.buf", 1, 1, 32'h600, 0, 0,      32'h404, 0);
    step32("exc",     1, 1, 32'h500, 1, 32'h80, 32'h80,  1);
    step32("exc.seq", 0, 0, 0,       0, 0,      32'h84,  0);

    // Live branch supersedes a buffered one.
    step32("sup.buf", 1, 1, 32'h700, 0, 0, 32'h84,  0);
    step32("sup.br",  0, 1, 32'h800, 0, 0, 32'h800, 1);
    step32("sup.seq", 0, 0, 0,       0, 0, 32'h804, 0);

    // Async reset between edges while a branch is buffered.
    step32("ar.buf", 1, 1, 32'h900, 0, 0, 32'h804, 0);
    stall32 = 1'b0; br32 = 1'b0;
    #3;
    rst32 = 1'b0;
    #1;
    check_val("ar.pc", pc32, 32'h100);
    check_val("ar.ce", {31'h0, ce32}, 32'h0);
    check_val("ar.red", {31'h0, red32}, 32'h0);
    @(posedge clk);
    #1;
    check_val("ar.hold", pc32, 32'h100);
    rst32 = 1'b1;
    step32("ar.boot", 0, 0, 0, 0, 0, 32'h100, 0);
    step32("ar.seq",  0, 0, 0, 0, 0, 32'h104, 0);
    step32("ar.seq2", 0, 0, 0, 0, 0, 32'h108, 0);

    // 8-bit instance: wrap and misalignment.
    check_val("r8.ce", {31'h0, ce8}, 32'h0);
    rst8 = 1'b1;
    step8("w.boot", 0, 8'h00, 8'h00, 0, 0);
    step8("w.seq",  0, 8'h00, 8'h04, 0, 0);
    step8("w.br",   1, 8'hFC, 8'hFC, 1, 0);
    step8("w.wrap", 0, 8'h00, 8'h00, 0, 0);
    step8("w.seq2", 0, 8'h00, 8'h04, 0, 0);
    step8("m.br",   1, 8'h02, 8'h02, 1, 1);
    step8("m.seq",  0, 8'h00, 8'h06, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
